mul_div_unit: RTL and testbench

//   Multi-cycle unsigned multiply/divide unit with HI/LO result registers.

---
 rtl/mul_div_unit_pkg.sv | 20 ++
 rtl/mul_div_unit.sv | 108 ++++++++++
 tb/tb_mul_div_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared funct codes and multiply/divide FSM state encoding.
// Used by the EX-stage ALU, ALU control and the multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock,
// with HI/LO result registers read back through MFHI/MFLO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_res;
  logic               no_borrow;

  // One WIDTH+1-bit adder serves both operations; DIV feeds it a + ~b + 1.
  always_comb begin
    add_a   = {1'b0, work[2*WIDTH-1:WIDTH]};
    add_b   = work[0] ? {1'b0, opnd} : '0;
    add_cin = 1'b0;
    if (state == ST_DIV) begin
      add_a   = work[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end
  end

  assign add_res   = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  assign no_borrow = add_res[WIDTH+1];

  always_comb begin
    work_next = {add_res[WIDTH:0], work[WIDTH-1:1]};
    if (state == ST_DIV) begin
      if (no_borrow)
        work_next = {add_res[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
      else
        work_next = {work[2*WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      work  <= '0;
      opnd  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (start && Signal == FUNCT_MULTU) begin
            state <= ST_MUL;
            work  <= {{WIDTH{1'b0}}, dataB};
            opnd  <= dataA;
          end else if (start && Signal == FUNCT_DIVU) begin
            state <= ST_DIV;
            work  <= {{WIDTH{1'b0}}, dataA};
            opnd  <= dataB;
          end
        end
        ST_MUL, ST_DIV: begin
          work  <= work_next;
          count <= count + 1'b1;
          // HI/LO change only here, so MFHI/MFLO keep the old result while busy.
          if (count == CW'(WIDTH - 1)) begin
            state <= ST_DONE;
            hi    <= work_next[2*WIDTH-1:WIDTH];
            lo    <= work_next[WIDTH-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_MUL) || (state == ST_DIV);
  assign done = (state == ST_DONE);

  always_comb begin
    case (Signal)
      FUNCT_MFHI: dataOut = hi;
      FUNCT_MFLO: dataOut = lo;
      default:    dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit: expected HI/LO pushed at issue,
// popped and compared by an independent monitor on every done pulse.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] dataA = '0;
  logic [WIDTH-1:0] dataB = '0;
  logic [5:0]       Signal = FUNCT_MFLO;
  logic             start = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;

  int checks = 0;
  int errors = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_hi = '0;
  logic [WIDTH-1:0] model_lo = '0;
  logic [WIDTH-1:0] pend_hi = '0;
  bit               hi_pending = 0;
  int               busy_cnt = 0;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .start(start), .busy(busy), .done(done), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] sig, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t             r;
    longint unsigned  p;
    if (sig == FUNCT_MULTU) begin
      p    = longint'(a) * longint'(b);
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 0) begin
      r.hi = a;
      r.lo = '1;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt   = 0;
      hi_pending = 0;
    end else begin
      if (hi_pending) begin
        if (Signal == FUNCT_MFHI) check("mfhi", dataOut, pend_hi);
        hi_pending = 0;
      end
      if (busy) begin
        busy_cnt++;
        if (Signal == FUNCT_MFLO) check("mflo_hold", dataOut, model_lo);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no operation outstanding at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("busy_len", WIDTH'(busy_cnt), WIDTH'(WIDTH));
          check("busy_in_done", WIDTH'(busy), '0);
          if (Signal == FUNCT_MFLO) check("mflo", dataOut, e.lo);
          model_hi   = e.hi;
          model_lo   = e.lo;
          pend_hi    = e.hi;
          hi_pending = 1;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [5:0] sig, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk); #1;
    Signal = sig;
    dataA  = a;
    dataB  = b;
    start  = 1'b1;
    if (sig == FUNCT_MULTU || sig == FUNCT_DIVU) exp_q.push_back(model(sig, a, b));
    @(posedge clk); #1;
    start  = 1'b0;
    Signal = FUNCT_MFLO;
    dataA  = $urandom;
    dataB  = $urandom;
  endtask

  task automatic wait_done(input bit read_hi);
    bit seen = 0;
    for (int i = 0; i < WIDTH + 8; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles at %0t", WIDTH + 8, $time);
    end
    if (read_hi) begin
      @(posedge clk); #1;
      Signal = FUNCT_MFHI;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state
    Signal = FUNCT_MFLO;
    repeat (2) @(negedge clk);
    check("rst_busy", WIDTH'(busy), '0);
    check("rst_done", WIDTH'(done), '0);
    check("rst_mflo", dataOut, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    issue(FUNCT_MULTU, 7, 6);
    wait_done(1);
    issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1);
    issue(FUNCT_DIVU, 100, 7);
    wait_done(1);
    issue(FUNCT_DIVU, 5, 0);
    wait_done(1);

    // Start while busy is ignored
    issue(FUNCT_MULTU, 3, 4);
    repeat (8) @(posedge clk);
    #1;
    Signal = FUNCT_DIVU; dataA = 9; dataB = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Signal = FUNCT_MFLO;
    wait_done(1);

    // Reset mid-operation aborts without a done pulse
    issue(FUNCT_DIVU, 1000, 7);
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    check("abort_busy", WIDTH'(busy), '0);
    check("abort_done", WIDTH'(done), '0);
    check("abort_lo", dataOut, '0);
    Signal = FUNCT_MFHI;
    #1;
    check("abort_hi", dataOut, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    Signal = FUNCT_MFLO;
    repeat (WIDTH + 4) @(negedge clk);
    issue(FUNCT_MULTU, 2, 3);
    wait_done(1);

    // Unknown code in IDLE is ignored; HI/LO unchanged
    @(posedge clk); #1;
    Signal = FUNCT_ADD; start = 1'b1;
    @(posedge clk); #1;
    Signal = FUNCT_MULT_FALLBACK();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ign_busy", WIDTH'(busy), '0);
      check("ign_done", WIDTH'(done), '0);
    end
    Signal = FUNCT_MFLO;
    #1;
    check("ign_lo", dataOut, model_lo);
    Signal = FUNCT_MFHI;
    #1;
    check("ign_hi", dataOut, model_hi);

    // Back-to-back: new start the cycle after done
    issue(FUNCT_MULTU, 123456, 789);
    wait_done(0);
    issue(FUNCT_MULTU, 32'h8000_0001, 32'h0000_FFFF);
    wait_done(1);

    // Randomized mix
    for (int n = 0; n < 24; n++) begin
      logic [5:0]       sig;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      sig = ($urandom_range(0, 1) == 0) ? FUNCT_MULTU : FUNCT_DIVU;
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = WIDTH'($urandom_range(0, 15));
        1:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      issue(sig, a, b);
      wait_done(n % 3 != 0);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_ops: %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Signed MULT funct code; the unit treats it as an unknown code.
  function automatic logic [5:0] FUNCT_MULT_FALLBACK();
    return 6'd24;
  endfunction

endmodule
